input_buffer: RTL and testbench
===============================

# input_buffer

- Per-input-port packet FIFO in each router, directly upstream of the router's routing/crossbar stage.
- Accepts packets from a network link (or local node) and holds them in order.
- Presents the head packet with an availability flag.
- Pops the head when the routing stage asserts its read strobe; one instance per router input port (four per router).

## Interface

Parameters:
- DEPTH, 4: packet slots; power of two, ≥2.

Ports:
- clock  input  1  sole clock; all state updates on posedge.
- reset_n  input  1  synchronous, active-low reset, sampled on posedge clock.
- put_valid  input  1  link offers a packet this cycle.
- put_pkt  input  pkt_t  packet offered by link (project packet struct, includes dest).
- put_ready  output  1  buffer can accept a packet this cycle.
- pkt_avail  output  1  head packet valid; drives routing stage pkt_in_avail[n].
- pkt_head  output  pkt_t  current head packet; drives routing stage pkt_in[n].
- read  input  1  pop head; driven by routing stage read_from_ib[n].
- occupancy  output  $clog2(DEPTH)+1  packets currently stored.
- overflow  output  1  sticky write-while-full error flag (see Configuration).

## Operation

- Storage: DEPTH-entry register array; write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits; count register $clog2(DEPTH)+1 bits.
- Pointers wrap naturally modulo DEPTH (DEPTH-1 → 0).
- put_ready = (count != DEPTH); depends only on registered count, never on same-cycle read.
- Push = put_valid && put_ready:
  - writes put_pkt to mem[wr_ptr];
  - wr_ptr increments.
- Pop = read && pkt_avail:
  - rd_ptr increments;
  - read while empty is ignored with no state change.
- count update:
  - push only: +1;
  - pop only: −1;
  - both or neither: unchanged.
- pkt_avail = (count != 0); pkt_head = mem[rd_ptr] (first-word fall-through, no output register).
- pkt_head value is don't-care while pkt_avail = 0; the bench must not check it.
- Ordering strictly FIFO; no packet dropped, duplicated or reordered.
- occupancy = count.
- Reset (reset_n low at posedge) clears:
  - wr_ptr, rd_ptr, count = 0, so pkt_avail = 0, put_ready = 1, occupancy = 0;
  - overflow = 0.
- Memory contents are not reset.
- Reset mid-operation discards all stored packets; a push or pop in the reset cycle has no effect.

## Timing

- Push at edge k → pkt_avail = 1 and pkt_head valid from edge k onward (visible in cycle k+1). Minimum write-to-read latency is one cycle; no combinational put→head bypass.
- Pop at edge k → next entry (if any) at pkt_head after edge k.
- Sustained throughput is one push and one pop per cycle at any occupancy 1..DEPTH−1.
- Full (count = DEPTH): put_ready = 0 even if read = 1 in the same cycle. The pop completes; put_ready rises the next cycle.
- Empty (count = 0): a simultaneous put_valid pushes and read is ignored. count becomes 1.
- read is combinational from pkt_head in the routing stage. The buffer has no combinational path from read to pkt_avail, pkt_head or put_ready.

## Configuration

- Macro IB_OVERFLOW_CHECK_EN.
- Defined:
  - overflow sets on any posedge where put_valid = 1 and put_ready = 0;
  - it stays set until reset;
  - the offered packet is not stored and no state changes.
- Not defined:
  - overflow is tied to 0 and no detection logic is built;
  - put_valid while full is still ignored.
- The port exists in both builds.

## Test plan

- Reset: hold reset_n = 0 for 2 cycles with put_valid = 1 → pkt_avail = 0, put_ready = 1, occupancy = 0, overflow = 0.
- Fill/drain, DEPTH = 4:
  - push packets with dest 0,1,2,3 on consecutive cycles → put_ready = 0 after the 4th push, occupancy = 4;
  - then pop 4 times → heads emerge with dest 0,1,2,3 in order; pkt_avail = 0 afterwards.
- Simultaneous push/pop:
  - occupancy 2, push and pop together for 10 cycles → occupancy stays 2;
  - output order equals input order across pointer wrap-around.
- Full with read:
  - occupancy 4, put_valid = 1 and read = 1 in the same cycle → the pop occurs, the push is refused, occupancy = 3;
  - the next cycle the push is accepted and occupancy returns to 4.
- Empty edge cases:
  - read = 1 while empty → no change;
  - push and read together while empty → occupancy = 1, and the pushed packet is at pkt_head the next cycle.
- Overflow with IB_OVERFLOW_CHECK_EN:
  - put_valid = 1 while full → overflow = 1 next cycle, and it stays 1 after draining;
  - the refused packet never appears at pkt_head;
  - without the macro, overflow stays 0.

Source files
------------

// File: rtl/input_buffer.sv
// Per-port packet FIFO with first-word fall-through head, feeding the router crossbar.
// Optional sticky write-while-full detection is built when IB_OVERFLOW_CHECK_EN is defined.
module input_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     put_valid,
    input  logic [DATA_W-1:0]        put_pkt,
    output logic                     put_ready,
    output logic                     pkt_avail,
    output logic [DATA_W-1:0]        pkt_head,
    input  logic                     read,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push;
    logic              pop;

    // Flow control looks only at registered count, so read never reaches put_ready.
    assign put_ready = (count_q != FULL_CNT);
    assign pkt_avail = (count_q != '0);
    assign pkt_head  = mem_q[rd_ptr_q];
    assign occupancy = count_q;

    always_comb begin
        push     = put_valid && put_ready;
        pop      = read && pkt_avail;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = put_pkt;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; stale slots are unreachable once pointers clear.
    always_ff @(posedge clock) begin
        if (reset_n) begin
            mem_q <= mem_d;
        end
    end

`ifdef IB_OVERFLOW_CHECK_EN
    logic overflow_q, overflow_d;

    always_comb begin
        overflow_d = overflow_q || (put_valid && !put_ready);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_input_buffer.sv
// Directed bench for input_buffer: reset, fill/drain, streaming across wrap, full/empty corners, overflow.
module tb_input_buffer;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 16;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              put_valid;
    logic [DATA_W-1:0] put_pkt;
    logic              put_ready;
    logic              pkt_avail;
    logic [DATA_W-1:0] pkt_head;
    logic              read;
    logic [2:0]        occupancy;
    logic              overflow;

    int n_chk = 0;
    int n_bad = 0;

`ifdef IB_OVERFLOW_CHECK_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    input_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .put_valid (put_valid),
        .put_pkt   (put_pkt),
        .put_ready (put_ready),
        .pkt_avail (pkt_avail),
        .pkt_head  (pkt_head),
        .read      (read),
        .occupancy (occupancy),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] pkt(input int dest);
        return 16'hC000 | DATA_W'(dest);
    endfunction

    task automatic fill(input int base);
        put_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            put_pkt = pkt(base + i);
            step();
        end
        put_valid = 1'b0;
    endtask

    task automatic drain(input int base, input int n);
        read = 1'b1;
        for (int i = 0; i < n; i++) begin
            check("drain_avail", 32'(pkt_avail), 32'd1);
            check("drain_head", 32'(pkt_head), 32'(pkt(base + i)));
            step();
        end
        read = 1'b0;
        check("drain_empty", 32'(pkt_avail), 32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        put_valid = 1'b1;
        put_pkt   = pkt(99);
        read      = 1'b0;
        step();
        step();
        check("rst_avail", 32'(pkt_avail), 32'd0);
        check("rst_ready", 32'(put_ready), 32'd1);
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        put_valid = 1'b0;
        reset_n   = 1'b1;
        step();

        // Fill then drain in order.
        put_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            put_pkt = pkt(i);
            step();
            check("fill_occ", 32'(occupancy), 32'(i + 1));
        end
        put_valid = 1'b0;
        check("full_ready", 32'(put_ready), 32'd0);
        check("full_avail", 32'(pkt_avail), 32'd1);
        drain(0, 4);
        check("drained_occ", 32'(occupancy), 32'd0);

        // Streaming at occupancy 2 across pointer wrap.
        put_valid = 1'b1;
        put_pkt   = pkt(10);
        step();
        put_pkt   = pkt(11);
        step();
        read = 1'b1;
        for (int i = 0; i < 10; i++) begin
            put_pkt = pkt(12 + i);
            check("stream_head", 32'(pkt_head), 32'(pkt(10 + i)));
            step();
            check("stream_occ", 32'(occupancy), 32'd2);
        end
        put_valid = 1'b0;
        read      = 1'b0;
        drain(20, 2);

        // Full with simultaneous read: pop happens, push refused.
        fill(30);
        put_valid = 1'b1;
        put_pkt   = pkt(34);
        read      = 1'b1;
        check("fr_ready_pre", 32'(put_ready), 32'd0);
        step();
        check("fr_occ3", 32'(occupancy), 32'd3);
        check("fr_ready", 32'(put_ready), 32'd1);
        check("fr_head", 32'(pkt_head), 32'(pkt(31)));
        read = 1'b0;
        step();
        put_valid = 1'b0;
        check("fr_occ4", 32'(occupancy), 32'd4);
        check("fr_ovf", 32'(overflow), 32'(OVF_EXP));
        drain(31, 4);

        // Empty corners.
        read = 1'b1;
        step();
        check("er_occ", 32'(occupancy), 32'd0);
        check("er_avail", 32'(pkt_avail), 32'd0);
        check("er_ready", 32'(put_ready), 32'd1);
        put_valid = 1'b1;
        put_pkt   = pkt(40);
        step();
        put_valid = 1'b0;
        read      = 1'b0;
        check("ep_occ", 32'(occupancy), 32'd1);
        check("ep_avail", 32'(pkt_avail), 32'd1);
        check("ep_head", 32'(pkt_head), 32'(pkt(40)));
        drain(40, 1);

        // Write while full: refused packet must never surface.
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("ovf_clr", 32'(overflow), 32'd0);
        fill(50);
        put_valid = 1'b1;
        put_pkt   = pkt(54);
        step();
        put_valid = 1'b0;
        check("ovf_occ", 32'(occupancy), 32'd4);
        check("ovf_set", 32'(overflow), 32'(OVF_EXP));
        drain(50, 4);
        check("ovf_sticky", 32'(overflow), 32'(OVF_EXP));
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("ovf_rst", 32'(overflow), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
